stack_sequencer: RTL and testbench

Command sequencer sitting directly upstream of the 32-bit operand stack: it accepts one stack command per bytecode from the decode/execute controller and turns it into pops, an ALU round-trip, and a push. It drives the stack's single-access trigger/push/done handshake and presents the popped operands to the ALU. It also returns a single completion pulse per command. Optionally it tracks stack depth and flags underflow and overflow.

---
 rtl/bali_stack_pkg.sv | 25 ++
 rtl/stack_depth_tracker.sv | 33 +++
 rtl/stack_sequencer.sv | 146 ++++++++++++++
 tb/tb_stack_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bali_stack_pkg.sv
// rtl/bali_stack_pkg.sv - shared states, pop-count constants and width default for the stack sequencer
package bali_stack_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [1:0] POP_NONE = 2'd0;
  localparam logic [1:0] POP_ONE  = 2'd1;
  localparam logic [1:0] POP_TWO  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    POP_REQ,
    POP_WAIT,
    EXEC,
    PUSH_REQ,
    PUSH_WAIT,
    FINISH
  } seq_state_t;

  // A pop_count of 3 behaves as 2.
  function automatic logic [1:0] clamp_pops(input logic [1:0] pc);
    return (pc == 2'd3) ? POP_TWO : pc;
  endfunction

endpackage

// File: rtl/stack_depth_tracker.sv
// rtl/stack_depth_tracker.sv - stack occupancy counter with empty/full flags
// Instantiated by stack_sequencer only when STACK_SEQ_DEPTH_CHECK_EN is defined.
module stack_depth_tracker
  import bali_stack_pkg::*;
#(
  parameter int DEPTH = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_empty,
  output logic o_full
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] r_depth;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_depth <= '0;
    end else if (i_inc && !i_dec) begin
      r_depth <= r_depth + CW'(1);
    end else if (i_dec && !i_inc) begin
      r_depth <= r_depth - CW'(1);
    end
  end

  assign o_empty = (r_depth == '0);
  assign o_full  = (r_depth == CW'(DEPTH));

endmodule

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - operand stack command sequencer: pops, ALU round-trip, push, done pulse
// Depth tracking with underflow/overflow error is enabled by defining STACK_SEQ_DEPTH_CHECK_EN.
module stack_sequencer
  import bali_stack_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = 65536
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       pop_count,
  input  logic             push_result,
  output logic             ready,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic             operands_valid,
  input  logic             result_valid,
  input  logic [WIDTH-1:0] result_value,
  output logic             done,
  output logic             error,
  output logic             stack_trigger,
  output logic             stack_push,
  output logic [WIDTH-1:0] stack_write_value,
  input  logic [WIDTH-1:0] stack_read_value,
  input  logic             stack_done
);

  seq_state_t       r_state;
  logic [1:0]       r_pops_left;
  logic             r_push;
  logic             r_second;
  logic             r_error;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_wval;

  logic             w_skip_pop;
  logic             w_skip_push;
  logic [1:0]       w_start_pops;
  seq_state_t       w_after_pop;

  assign w_start_pops = clamp_pops(pop_count);
  assign w_after_pop  = (r_pops_left > POP_ONE) ? POP_REQ : (r_push ? EXEC : FINISH);

`ifdef STACK_SEQ_DEPTH_CHECK_EN
  logic w_empty;
  logic w_full;

  stack_depth_tracker #(.DEPTH(DEPTH)) u_depth (
    .clk     (clk),
    .rst     (rst),
    .i_inc   ((r_state == PUSH_WAIT) && stack_done),
    .i_dec   ((r_state == POP_WAIT) && stack_done),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign w_skip_pop  = w_empty;
  assign w_skip_push = w_full;
`else
  logic w_unused_depth;
  assign w_unused_depth = (DEPTH > 0);
  assign w_skip_pop     = 1'b0;
  assign w_skip_push    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pops_left <= POP_NONE;
      r_push      <= 1'b0;
      r_second    <= 1'b0;
      r_error     <= 1'b0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_wval      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_pops_left <= w_start_pops;
            r_push      <= push_result;
            r_second    <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            if (w_start_pops != POP_NONE) r_state <= POP_REQ;
            else if (push_result)         r_state <= EXEC;
            else                          r_state <= FINISH;
          end
        end
        POP_REQ: begin
          // An underflowing pop is counted as done without touching the stack.
          if (w_skip_pop) begin
            r_error     <= 1'b1;
            r_second    <= 1'b1;
            r_pops_left <= r_pops_left - 2'd1;
            r_state     <= w_after_pop;
          end else begin
            r_state <= POP_WAIT;
          end
        end
        POP_WAIT: begin
          if (stack_done) begin
            if (r_second) r_op_b <= stack_read_value;
            else          r_op_a <= stack_read_value;
            r_second    <= 1'b1;
            r_pops_left <= r_pops_left - 2'd1;
            r_state     <= w_after_pop;
          end
        end
        EXEC: begin
          if (result_valid) begin
            r_wval  <= result_value;
            r_state <= PUSH_REQ;
          end
        end
        PUSH_REQ: begin
          if (w_skip_push) begin
            r_error <= 1'b1;
            r_state <= FINISH;
          end else begin
            r_state <= PUSH_WAIT;
          end
        end
        PUSH_WAIT: begin
          if (stack_done) r_state <= FINISH;
        end
        FINISH:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready             = (r_state == IDLE);
  assign operands_valid    = (r_state == EXEC);
  assign done              = (r_state == FINISH);
  assign stack_push        = (r_state == PUSH_REQ);
  assign stack_trigger     = ((r_state == POP_REQ) && !w_skip_pop) ||
                             ((r_state == PUSH_REQ) && !w_skip_push);
  assign operand_a         = r_op_a;
  assign operand_b         = r_op_b;
  assign stack_write_value = r_wval;
  assign error             = r_error;

endmodule

// File: tb/tb_stack_sequencer.sv
// tb/tb_stack_sequencer.sv - self-checking bench for stack_sequencer against a queue-based stack model
// Covers STACK_SEQ_DEPTH_CHECK_EN behaviour when that macro is defined for the build.
module tb_stack_sequencer;

  localparam int W = 32;
  localparam int D = 16;
`ifdef STACK_SEQ_DEPTH_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   pop_count = 2'd0;
  logic         push_result = 1'b0;
  logic         ready;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         operands_valid;
  logic         result_valid = 1'b0;
  logic [W-1:0] result_value = '0;
  logic         done;
  logic         error;
  logic         stack_trigger;
  logic         stack_push;
  logic [W-1:0] stack_write_value;
  logic [W-1:0] stack_read_value = '0;
  logic         stack_done = 1'b0;

  int total = 0;
  int bad = 0;

  logic [W-1:0] dev_q[$];
  logic [W-1:0] ref_q[$];
  int           stack_lat = 2;
  int           alu_delay = 0;
  logic [W-1:0] alu_value = '0;
  int           n_done = 0;
  int           n_pop_trig = 0;
  int           n_push_trig = 0;
  logic         exp_err = 1'b0;
  logic         rsp_is_push;
  logic [W-1:0] rsp_wval;

  stack_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .pop_count         (pop_count),
    .push_result       (push_result),
    .ready             (ready),
    .operand_a         (operand_a),
    .operand_b         (operand_b),
    .operands_valid    (operands_valid),
    .result_valid      (result_valid),
    .result_value      (result_value),
    .done              (done),
    .error             (error),
    .stack_trigger     (stack_trigger),
    .stack_push        (stack_push),
    .stack_write_value (stack_write_value),
    .stack_read_value  (stack_read_value),
    .stack_done        (stack_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Event counters sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (done === 1'b1) n_done++;
    if (stack_trigger === 1'b1) begin
      if (stack_push === 1'b1) n_push_trig++;
      else                     n_pop_trig++;
    end
  end

  // Stack device: answers each trigger stack_lat cycles later with a one-cycle done.
  initial forever begin
    @(negedge clk);
    if (stack_trigger === 1'b1) begin
      rsp_is_push = stack_push;
      rsp_wval    = stack_write_value;
      repeat (stack_lat) @(posedge clk);
      #1;
      if (rsp_is_push) dev_q.push_back(rsp_wval);
      else stack_read_value = (dev_q.size() > 0) ? dev_q.pop_back() : '0;
      stack_done = 1'b1;
      @(posedge clk);
      #1;
      stack_done       = 1'b0;
      stack_read_value = $urandom;
    end
  end

  // ALU: returns alu_value alu_delay cycles into EXEC.
  initial forever begin
    @(negedge clk);
    if (operands_valid === 1'b1) begin
      repeat (alu_delay) @(negedge clk);
      result_value = alu_value;
      result_valid = 1'b1;
      @(posedge clk);
      #1;
      result_valid = 1'b0;
      result_value = $urandom;
    end
  end

  task automatic do_cmd(input logic [1:0] pc, input logic pr, input logic [W-1:0] av,
                        input bit busy_poke, input string tag);
    int pops, cyc, done0, pt0, ut0, exp_pt, exp_ut, exp_cyc;
    logic [W-1:0] ea, eb, oa, ob, v;
    bit skipped, saw_ov;
    pops = (pc == 2'd3) ? 2 : int'(pc);
    ea = '0; eb = '0; oa = '0; ob = '0;
    exp_pt = 0; exp_ut = 0; skipped = 0; saw_ov = 0;
    for (int i = 0; i < pops; i++) begin
      v = '0;
      if (!CHK || ref_q.size() > 0) begin
        v = ref_q.pop_back();
        exp_pt++;
      end else begin
        skipped = 1; exp_err = 1'b1;
      end
      if (i == 0) ea = v; else eb = v;
    end
    if (pr) begin
      if (!CHK || ref_q.size() < D) begin
        ref_q.push_back(av);
        exp_ut++;
      end else begin
        skipped = 1; exp_err = 1'b1;
      end
    end
    exp_cyc = 1 + pops * (1 + stack_lat) + (pr ? (alu_delay + 1) + (1 + stack_lat) : 0);

    cyc = 0;
    while (ready !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    alu_value = av;
    @(negedge clk);
    pt0 = n_pop_trig; ut0 = n_push_trig; done0 = n_done;
    start = 1'b1; pop_count = pc; push_result = pr;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (busy_poke) begin pop_count = 2'd2; push_result = 1'b1; end
    cyc = 1;
    @(negedge clk);
    while (done !== 1'b1 && cyc < 300) begin
      if (operands_valid === 1'b1 && !saw_ov) begin saw_ov = 1; oa = operand_a; ob = operand_b; end
      if (busy_poke) start = (cyc == 3);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, " done_seen"}, done, 1'b1);
    if (!skipped) chk({tag, " done_cycle"}, cyc, exp_cyc);
    chk({tag, " operand_a"}, operand_a, ea);
    chk({tag, " operand_b"}, operand_b, eb);
    if (pr) begin
      chk({tag, " ov_seen"}, saw_ov, 1'b1);
      chk({tag, " ov_operand_a"}, oa, ea);
      chk({tag, " ov_operand_b"}, ob, eb);
    end
    @(negedge clk);
    chk({tag, " ready_after"}, ready, 1'b1);
    @(negedge clk);
    chk({tag, " done_count"}, n_done - done0, 1);
    chk({tag, " pop_trigs"}, n_pop_trig - pt0, exp_pt);
    chk({tag, " push_trigs"}, n_push_trig - ut0, exp_ut);
    chk({tag, " error"}, error, exp_err);
    chk({tag, " stack_size"}, dev_q.size(), ref_q.size());
    if (ref_q.size() > 0 && dev_q.size() > 0) chk({tag, " stack_top"}, dev_q[$], ref_q[$]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rpc;
    logic       rpr;
    int         rnp, d0, p0, u0;

    repeat (3) @(negedge clk);
    chk("rst ready", ready, 1'b1);
    chk("rst done", done, 1'b0);
    chk("rst operands_valid", operands_valid, 1'b0);
    chk("rst stack_trigger", stack_trigger, 1'b0);
    chk("rst stack_push", stack_push, 1'b0);
    chk("rst error", error, 1'b0);
    chk("rst operand_a", operand_a, '0);
    chk("rst operand_b", operand_b, '0);
    chk("rst write_value", stack_write_value, '0);
    rst = 1'b0;

    stack_lat = 2; alu_delay = 0;
    do_cmd(2'd0, 1'b0, '0, 0, "noop");

    if (CHK) do_cmd(2'd1, 1'b1, 32'd3, 0, "underflow");

    do_cmd(2'd0, 1'b1, 32'hDEADBEEF, 0, "push_only");
    chk("push_only write_value", stack_write_value, 32'hDEADBEEF);

    do_cmd(2'd0, 1'b1, 32'd7, 0, "push7");
    do_cmd(2'd0, 1'b1, 32'd5, 0, "push5");
    do_cmd(2'd2, 1'b1, 32'd12, 0, "pop2_push");
    do_cmd(2'd1, 1'b0, '0, 0, "pop_back12");

    do_cmd(2'd0, 1'b1, 32'd9, 0, "push9");
    do_cmd(2'd1, 1'b0, '0, 1, "pop1_busy_poke");

    for (int n = 0; n < 40; n++) begin
      rpc = 2'($urandom_range(0, 3));
      rpr = 1'($urandom_range(0, 1));
      rnp = (rpc == 2'd3) ? 2 : int'(rpc);
      if (!CHK && rnp > ref_q.size()) rpc = 2'((ref_q.size() > 2) ? 2 : ref_q.size());
      if (ref_q.size() >= 12) rpr = 1'b0;
      stack_lat = $urandom_range(1, 3);
      alu_delay = $urandom_range(0, 2);
      do_cmd(rpc, rpr, W'($urandom), 0, "rand");
    end

    // Abandon a pop mid-flight: reset lands in POP_WAIT, the stack answers afterwards.
    stack_lat = 2; alu_delay = 0;
    if (ref_q.size() == 0) do_cmd(2'd0, 1'b1, 32'h55, 0, "prefill");
    @(negedge clk);
    start = 1'b1; pop_count = 2'd1; push_result = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    d0 = n_done; p0 = n_pop_trig; u0 = n_push_trig;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_mid ready", ready, 1'b1);
    chk("reset_mid operand_a", operand_a, '0);
    chk("reset_mid operand_b", operand_b, '0);
    chk("reset_mid error", error, 1'b0);
    repeat (5) @(negedge clk);
    chk("reset_mid ready_later", ready, 1'b1);
    chk("reset_mid no_done", n_done - d0, 0);
    chk("reset_mid no_trig", (n_pop_trig - p0) + (n_push_trig - u0), 0);
    ref_q.delete();
    dev_q.delete();
    exp_err = 1'b0;

    do_cmd(2'd0, 1'b0, '0, 0, "noop_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
